// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin arbiter sharing one data-memory port among
// NUM_CORES cores, one transaction in flight at a time, plus aggregation of
// per-core completion into a sticky cluster-level end_process flag.
module core_mem_arbiter #(
  parameter int NUM_CORES = 16,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_CORES-1:0]          core_en,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          we,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata,
  input  logic [NUM_CORES-1:0]          core_done,
  output logic [NUM_CORES-1:0]          ack,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          end_process
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [2:0] LAT = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       r_grant;
  logic [2:0]             r_cnt;
  logic                   r_post_ack;
  logic [NUM_CORES-1:0]   r_ack;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_mem_en;
  logic                   r_mem_we;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_mem_wdata;
  logic [NUM_CORES-1:0]   r_done_seen;
  logic                   r_end;

  logic [NUM_CORES-1:0]   w_mask;
  logic [NUM_CORES-1:0]   w_elig;
  logic                   w_any;
  logic [PTR_W-1:0]       w_gnt_idx;
  logic [NUM_CORES-1:0]   w_ack_nxt;
  logic [DATA_W-1:0]      w_rdata_nxt;
  logic                   w_mem_en_nxt;
  logic                   w_mem_we_nxt;
  logic [ADDR_W-1:0]      w_mem_addr_nxt;
  logic [DATA_W-1:0]      w_mem_wdata_nxt;
  logic [2:0]             w_cnt_nxt;
  logic [NUM_CORES-1:0]   w_done_nxt;
  logic                   w_end_nxt;

  // Eligible set and round-robin search starting just after the last grant;
  // the core acked last cycle is hidden for one IDLE cycle to avoid a double grant.
  always_comb begin : p_grant
    int idx;
    if (r_post_ack) begin
      w_mask = NUM_CORES'(1) << r_grant;
    end else begin
      w_mask = '0;
    end
    w_elig    = req & core_en & ~w_mask;
    w_any     = 1'b0;
    w_gnt_idx = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx = (int'(r_ptr) + k) % NUM_CORES;
      if (!w_any && w_elig[idx]) begin
        w_any     = 1'b1;
        w_gnt_idx = PTR_W'(idx);
      end else begin
        w_any     = w_any;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> ACK -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_cnt >= LAT) begin
          w_state_nxt = S_ACK;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered memory/ack/rdata outputs,
  // the WAIT counter and completion tracking.
  always_comb begin
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_ack_nxt       = '0;
    w_rdata_nxt     = r_rdata;
    w_cnt_nxt       = r_cnt;

    if (r_state == S_IDLE && w_any) begin
      w_mem_en_nxt    = 1'b1;
      w_mem_we_nxt    = we[w_gnt_idx];
      w_mem_addr_nxt  = addr[w_gnt_idx*ADDR_W +: ADDR_W];
      w_mem_wdata_nxt = wdata[w_gnt_idx*DATA_W +: DATA_W];
    end else begin
      w_mem_en_nxt    = 1'b0;
    end

    if (r_state == S_ISSUE) begin
      w_cnt_nxt = 3'd1;
    end else if (r_state == S_WAIT && r_cnt < LAT) begin
      w_cnt_nxt = r_cnt + 3'd1;
    end else begin
      w_cnt_nxt = r_cnt;
    end

    if (r_state == S_WAIT && w_state_nxt == S_ACK) begin
      w_rdata_nxt = mem_rdata;
      w_ack_nxt   = NUM_CORES'(1) << r_grant;
    end else begin
      w_rdata_nxt = r_rdata;
      w_ack_nxt   = '0;
    end

    // start wins over a coincident core_done
    if (start) begin
      w_done_nxt = '0;
      w_end_nxt  = 1'b0;
    end else begin
      w_done_nxt = r_done_seen | core_done;
      w_end_nxt  = r_end |
                   ((core_en != '0) && ((w_done_nxt & core_en) == core_en));
    end
  end

  // Datapath and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= PTR_W'(NUM_CORES - 1);
      r_grant     <= '0;
      r_cnt       <= 3'd0;
      r_post_ack  <= 1'b0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done_seen <= '0;
      r_end       <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_ptr   <= w_gnt_idx;
        r_grant <= w_gnt_idx;
      end else begin
        r_ptr   <= r_ptr;
        r_grant <= r_grant;
      end
      r_cnt       <= w_cnt_nxt;
      r_post_ack  <= (r_state == S_ACK);
      r_ack       <= w_ack_nxt;
      r_rdata     <= w_rdata_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_done_seen <= w_done_nxt;
      r_end       <= w_end_nxt;
    end
  end

  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign end_process = r_end;

endmodule
